// File: rtl/pc_alu_exec_unit_if.sv
// Operand, control and result bundle for pc_alu_exec_unit.
// The master drives instruction fields and operands; the slave (the unit) returns PC and ALU outputs.
interface pc_alu_exec_unit_if;
  logic        pc_en;
  logic        branch;
  logic [31:0] imm_ext;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] oper1;
  logic [31:0] oper2;
  logic [31:0] pc_out;
  logic [3:0]  alu_cmd;
  logic [31:0] result;
  logic        overflow;
  logic        zero;

  modport master (
    output pc_en, branch, imm_ext, alu_op, funct, shamt, oper1, oper2,
    input  pc_out, alu_cmd, result, overflow, zero
  );

  modport slave (
    input  pc_en, branch, imm_ext, alu_op, funct, shamt, oper1, oper2,
    output pc_out, alu_cmd, result, overflow, zero
  );
endinterface

// File: rtl/pc_alu_exec_unit.sv
// Execute-stage core: program counter, ALU-control decoder and 32-bit ALU.
// Define PC_ALU_SHIFT_EN to build the SLL/SRL/SRA shifter; without it shift functs decode to ADD.
module pc_alu_exec_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned PC_STEP    = 4
) (
  input logic              clk,
  input logic              clr,
  pc_alu_exec_unit_if.slave bus
);

  typedef enum logic [3:0] {
    CMD_AND  = 4'b0000,
    CMD_OR   = 4'b0001,
    CMD_ADD  = 4'b0010,
    CMD_XOR  = 4'b0011,
    CMD_SLL  = 4'b0100,
    CMD_SRL  = 4'b0101,
    CMD_SUB  = 4'b0110,
    CMD_SLT  = 4'b0111,
    CMD_SRA  = 4'b1000,
    CMD_SLTU = 4'b1001,
    CMD_LUI  = 4'b1010,
    CMD_ADDU = 4'b1011,
    CMD_NOR  = 4'b1100,
    CMD_SUBU = 4'b1101
  } alu_cmd_e;

  alu_cmd_e    cmd;
  logic [31:0] pc_q, pc_d;
  logic [31:0] sum, diff, res;
  logic        ovf;
  logic        is_zero;

  always_comb begin
    cmd = CMD_ADD;
    case (bus.alu_op)
      4'b0000: cmd = CMD_ADD;
      4'b0001: cmd = CMD_SUB;
      4'b0010: begin
        case (bus.funct)
          6'h20:   cmd = CMD_ADD;
          6'h21:   cmd = CMD_ADDU;
          6'h22:   cmd = CMD_SUB;
          6'h23:   cmd = CMD_SUBU;
          6'h24:   cmd = CMD_AND;
          6'h25:   cmd = CMD_OR;
          6'h26:   cmd = CMD_XOR;
          6'h27:   cmd = CMD_NOR;
          6'h2A:   cmd = CMD_SLT;
          6'h2B:   cmd = CMD_SLTU;
`ifdef PC_ALU_SHIFT_EN
          6'h00:   cmd = CMD_SLL;
          6'h02:   cmd = CMD_SRL;
          6'h03:   cmd = CMD_SRA;
`endif
          default: cmd = CMD_ADD;
        endcase
      end
      4'b0011: cmd = CMD_AND;
      4'b0100: cmd = CMD_OR;
      4'b0101: cmd = CMD_SLT;
      4'b0110: cmd = CMD_LUI;
      4'b0111: cmd = CMD_XOR;
      4'b1000: cmd = CMD_SLTU;
      default: cmd = CMD_ADD;
    endcase
  end

  // Only the signed ADD/SUB commands flag overflow; the unsigned forms and unused codes do not.
  always_comb begin
    sum  = bus.oper1 + bus.oper2;
    diff = bus.oper1 - bus.oper2;
    res  = 32'h0;
    ovf  = 1'b0;
    case (cmd)
      CMD_ADD: begin
        res = sum;
        ovf = (bus.oper1[31] == bus.oper2[31]) && (sum[31] != bus.oper1[31]);
      end
      CMD_SUB: begin
        res = diff;
        ovf = (bus.oper1[31] != bus.oper2[31]) && (diff[31] != bus.oper1[31]);
      end
      CMD_ADDU: res = sum;
      CMD_SUBU: res = diff;
      CMD_AND:  res = bus.oper1 & bus.oper2;
      CMD_OR:   res = bus.oper1 | bus.oper2;
      CMD_XOR:  res = bus.oper1 ^ bus.oper2;
      CMD_NOR:  res = ~(bus.oper1 | bus.oper2);
      CMD_SLT:  res = {31'h0, $signed(bus.oper1) < $signed(bus.oper2)};
      CMD_SLTU: res = {31'h0, bus.oper1 < bus.oper2};
      CMD_LUI:  res = {bus.oper2[15:0], 16'h0};
`ifdef PC_ALU_SHIFT_EN
      CMD_SLL:  res = bus.oper2 << bus.shamt;
      CMD_SRL:  res = bus.oper2 >> bus.shamt;
      CMD_SRA:  res = $unsigned($signed(bus.oper2) >>> bus.shamt);
`endif
      default:  res = 32'h0;
    endcase
  end

`ifndef PC_ALU_SHIFT_EN
  logic unused_shamt;
  assign unused_shamt = ^bus.shamt;
`endif

  assign is_zero = (res == 32'h0);

  // Branch target is relative to the sequential PC; all arithmetic wraps modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (bus.pc_en) begin
      if (bus.branch && is_zero) begin
        pc_d = pc_q + 32'(PC_STEP) + (bus.imm_ext << 2);
      end else begin
        pc_d = pc_q + 32'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc_out   = pc_q;
  assign bus.alu_cmd  = cmd;
  assign bus.result   = res;
  assign bus.overflow = ovf;
  assign bus.zero     = is_zero;

endmodule

// File: tb/tb_pc_alu_exec_unit.sv
// Directed self-checking bench for pc_alu_exec_unit: PC sequencing, branches, wrap and ALU decode.
// Shift expectations follow whether PC_ALU_SHIFT_EN is defined for the build.
module tb_pc_alu_exec_unit;
  logic clk;
  logic clr;
  int   pass_count;
  int   check_count;

  pc_alu_exec_unit_if bus ();

  pc_alu_exec_unit #(
    .RESET_ADDR(32'h0000_0000),
    .PC_STEP   (4)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] sh,
                               input logic [31:0] a, input logic [31:0] b);
    bus.alu_op = op;
    bus.funct  = fn;
    bus.shamt  = sh;
    bus.oper1  = a;
    bus.oper2  = b;
    #1;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    clr         = 1'b1;
    bus.pc_en   = 1'b0;
    bus.branch  = 1'b0;
    bus.imm_ext = 32'h0;
    applyStimulus(4'b0000, 6'h00, 5'd0, 32'd1, 32'd1);
    #2;
    checkOutput("reset_pc", bus.pc_out, 32'h0);
    #10;
    clr       = 1'b0;
    bus.pc_en = 1'b1;
    stepEdge();
    stepEdge();
    checkOutput("pre_clr_pc", bus.pc_out, 32'h8);

    // Asynchronous clear in the middle of a cycle, then held across an edge
    #2;
    clr = 1'b1;
    #1;
    checkOutput("async_clr", bus.pc_out, 32'h0);
    stepEdge();
    checkOutput("clr_held", bus.pc_out, 32'h0);
    clr = 1'b0;
    stepEdge();
    checkOutput("seq_pc1", bus.pc_out, 32'h4);
    stepEdge();
    checkOutput("seq_pc2", bus.pc_out, 32'h8);
    stepEdge();
    checkOutput("seq_pc3", bus.pc_out, 32'hC);
    bus.pc_en = 1'b0;
    stepEdge();
    checkOutput("hold_pc", bus.pc_out, 32'hC);
    bus.pc_en = 1'b1;
    stepEdge();
    checkOutput("seq_pc4", bus.pc_out, 32'h10);

    // Branches: SUB 5-5 gives zero
    bus.branch  = 1'b1;
    bus.imm_ext = 32'd3;
    applyStimulus(4'b0001, 6'h00, 5'd0, 32'd5, 32'd5);
    checkOutput("br_zero", {31'h0, bus.zero}, 32'd1);
    stepEdge();
    checkOutput("br_fwd", bus.pc_out, 32'h20);
    bus.imm_ext = 32'hFFFF_FFFE;
    stepEdge();
    checkOutput("br_back", bus.pc_out, 32'h1C);
    applyStimulus(4'b0001, 6'h00, 5'd0, 32'd5, 32'd6);
    checkOutput("br_nz", {31'h0, bus.zero}, 32'd0);
    stepEdge();
    checkOutput("br_not_taken", bus.pc_out, 32'h20);
    bus.imm_ext = 32'hFFFF_FFF6;
    applyStimulus(4'b0001, 6'h00, 5'd0, 32'd5, 32'd5);
    stepEdge();
    checkOutput("br_to_top", bus.pc_out, 32'hFFFF_FFFC);
    bus.branch = 1'b0;
    stepEdge();
    checkOutput("pc_wrap", bus.pc_out, 32'h0);
    bus.pc_en = 1'b0;

    // R-type arithmetic
    applyStimulus(4'b0010, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h1);
    checkOutput("add_res", bus.result, 32'h8000_0000);
    checkOutput("add_ovf", {31'h0, bus.overflow}, 32'd1);
    checkOutput("add_cmd", {28'h0, bus.alu_cmd}, 32'h2);
    applyStimulus(4'b0010, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'h1);
    checkOutput("addu_res", bus.result, 32'h8000_0000);
    checkOutput("addu_ovf", {31'h0, bus.overflow}, 32'd0);
    checkOutput("addu_cmd", {28'h0, bus.alu_cmd}, 32'hB);
    applyStimulus(4'b0010, 6'h22, 5'd0, 32'd5, 32'd5);
    checkOutput("sub_res", bus.result, 32'h0);
    checkOutput("sub_zero", {31'h0, bus.zero}, 32'd1);
    applyStimulus(4'b0001, 6'h00, 5'd0, 32'h8000_0000, 32'h1);
    checkOutput("sub_ovf_res", bus.result, 32'h7FFF_FFFF);
    checkOutput("sub_ovf", {31'h0, bus.overflow}, 32'd1);
    applyStimulus(4'b0010, 6'h23, 5'd0, 32'h8000_0000, 32'h1);
    checkOutput("subu_ovf", {31'h0, bus.overflow}, 32'd0);

    // Logic and compare
    applyStimulus(4'b0010, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'h1);
    checkOutput("slt", bus.result, 32'h1);
    applyStimulus(4'b0010, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'h1);
    checkOutput("sltu", bus.result, 32'h0);
    checkOutput("sltu_zero", {31'h0, bus.zero}, 32'd1);
    applyStimulus(4'b0010, 6'h27, 5'd0, 32'h0, 32'h0);
    checkOutput("nor", bus.result, 32'hFFFF_FFFF);
    checkOutput("nor_cmd", {28'h0, bus.alu_cmd}, 32'hC);
    applyStimulus(4'b0111, 6'h00, 5'd0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    checkOutput("xor", bus.result, 32'hFF00_EDCB);
    applyStimulus(4'b0011, 6'h00, 5'd0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    checkOutput("and", bus.result, 32'h00F0_1234);

    // Shift and LUI
    applyStimulus(4'b0010, 6'h03, 5'd4, 32'h0, 32'h8000_0000);
`ifdef PC_ALU_SHIFT_EN
    checkOutput("sra_res", bus.result, 32'hF800_0000);
    checkOutput("sra_cmd", {28'h0, bus.alu_cmd}, 32'h8);
    applyStimulus(4'b0010, 6'h00, 5'd4, 32'h0, 32'h0000_0123);
    checkOutput("sll_res", bus.result, 32'h0000_1230);
`else
    checkOutput("sra_as_add_cmd", {28'h0, bus.alu_cmd}, 32'h2);
    checkOutput("sra_as_add_res", bus.result, 32'h8000_0000);
`endif
    applyStimulus(4'b0110, 6'h00, 5'd0, 32'h0, 32'h0000_1234);
    checkOutput("lui_res", bus.result, 32'h1234_0000);
    checkOutput("lui_cmd", {28'h0, bus.alu_cmd}, 32'hA);
    applyStimulus(4'b1111, 6'h00, 5'd0, 32'd2, 32'd3);
    checkOutput("op_default", bus.result, 32'd5);
    applyStimulus(4'b0010, 6'h3F, 5'd0, 32'd2, 32'd3);
    checkOutput("funct_default", {28'h0, bus.alu_cmd}, 32'h2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule

// File: doc/pc_alu_exec_unit.md
Name: pc_alu_exec_unit

Overview:
- Execute-stage core of the single-cycle MIPS datapath. Contains three parts:
  - the 32-bit program counter register;
  - the ALU-control decoder, which maps the main-control ALU op plus the funct field to a 4-bit ALU command;
  - the 32-bit ALU, which produces the result, overflow and zero flags.
- The zero flag drives the conditional-branch PC update.

Parameters:
- RESET_ADDR, 32'h0000_0000: PC value loaded on reset.
- PC_STEP, 4: sequential PC increment in bytes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  asynchronous, active-high reset.
- pc_en  input  1  PC update enable; when 0 the PC holds.
- branch  input  1  conditional-branch request from main control.
- imm_ext  input  32  sign-extended 16-bit immediate (branch offset in words; also used for LUI).
- alu_op  input  4  ALU op class from main control.
- funct  input  6  instruction[5:0].
- shamt  input  5  instruction[10:6].
- oper1  input  32  ALU operand A (rs data).
- oper2  input  32  ALU operand B (rt data or immediate, muxed outside this block).
- pc_out  output  32  current PC.
- alu_cmd  output  4  decoded ALU command.
- result  output  32  ALU result.
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset: clr high forces pc_out = RESET_ADDR immediately, independent of clk. It is held while clr is high. All other outputs are combinational.
- PC update on each rising edge with clr low:
  - pc_en = 0: hold.
  - branch && zero: pc <= pc + PC_STEP + (imm_ext << 2).
  - otherwise: pc <= pc + PC_STEP.
  - All PC arithmetic is modulo 2^32 (wraps, no error).
- alu_op decode (combinational):
  - 0000 ADD
  - 0001 SUB
  - 0010 use funct
  - 0011 AND
  - 0100 OR
  - 0101 SLT
  - 0110 LUI
  - 0111 XOR
  - 1000 SLTU
  - any other value: ADD
- funct decode when alu_op = 0010:
  - 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
  - 0x2A SLT, 0x2B SLTU
  - 0x00 SLL, 0x02 SRL, 0x03 SRA
  - any other value: ADD
- alu_cmd encoding:
  - AND 0000, OR 0001, ADD 0010, XOR 0011
  - SLL 0100, SRL 0101, SUB 0110, SLT 0111
  - SRA 1000, SLTU 1001, LUI 1010, ADDU 1011
  - NOR 1100, SUBU 1101
  - Unused codes (1110, 1111) give result 0.
- ALU operations (combinational, same cycle as inputs):
  - ADD/ADDU: oper1 + oper2.
  - SUB/SUBU: oper1 - oper2.
  - Logic ops are bitwise.
  - SLT: signed compare; SLTU: unsigned compare. Both give 32'd1 or 32'd0.
  - SLL/SRL/SRA shift oper2 by shamt. SRA replicates oper2[31].
  - LUI: {oper2[15:0], 16'h0}.
- overflow:
  - ADD: set when both operands have the same sign and the result sign differs.
  - SUB: set when the operand signs differ and the result sign differs from oper1.
  - 0 for every other command, including ADDU and SUBU.
  - Result is still the wrapped sum/difference; overflow does not trap.
- zero = (result == 32'h0), for every command.
- Simultaneous clr and clock edge: clr wins. On clr release, the first edge performs a normal update.

Optional Feature:
- Macro PC_ALU_SHIFT_EN.
- Defined: SLL/SRL/SRA decode and execute as specified.
- Undefined:
  - funct 0x00, 0x02 and 0x03 decode to ADD.
  - alu_cmd codes 0100, 0101 and 1000 produce result 0.
  - No shifter logic is synthesized.

Test Plan:
- Reset/sequential:
  - Assert clr mid-cycle → pc_out = 0 immediately.
  - Release clr, pc_en = 1, branch = 0, 3 edges → pc_out = 4, 8, 12.
  - pc_en = 0 → pc_out holds 12.
- Branch taken:
  - pc = 0x10, branch = 1, alu_op = 0001, oper1 = oper2 = 5, imm_ext = 3 → zero = 1; next pc = 0x20.
  - Same with imm_ext = 32'hFFFF_FFFE → next pc = 0x0C.
  - With oper2 = 6 → zero = 0; next pc = 0x14.
- R-type arithmetic:
  - funct 0x20, 32'h7FFF_FFFF + 1 → result 32'h8000_0000, overflow = 1.
  - funct 0x21, same operands → overflow = 0.
  - funct 0x22, 5 - 5 → result 0, zero = 1.
- Logic/compare:
  - funct 0x2A, oper1 = 32'hFFFF_FFFF, oper2 = 1 → result 1.
  - funct 0x2B, same operands → result 0.
  - funct 0x27, 0 NOR 0 → result 32'hFFFF_FFFF.
- Shift/LUI:
  - funct 0x03, oper2 = 32'h8000_0000, shamt = 4 → result 32'hF800_0000 (macro defined).
  - Same with macro undefined → alu_cmd = 0010.
  - alu_op = 0110, oper2 = 32'h0000_1234 → result 32'h1234_0000.
- Wrap: pc = 32'hFFFF_FFFC, one sequential edge → pc_out = 0.
